// File: rtl/wb_axil_xbar_bridge_if.sv
// rtl/wb_axil_xbar_bridge_if.sv - Wishbone-classic slave plus NUM_PORTS AXI4-Lite master signal bundle
interface wb_axil_xbar_bridge_if #(
  parameter int NUM_PORTS = 4,
  parameter int AW        = 32
);
  logic                      wb_cyc_i;
  logic                      wb_stb_i;
  logic                      wb_we_i;
  logic [AW-1:0]             wb_adr_i;
  logic [31:0]               wb_dat_i;
  logic [3:0]                wb_sel_i;
  logic                      wb_ack_o;
  logic                      wb_err_o;
  logic [31:0]               wb_dat_o;

  logic [NUM_PORTS*AW-1:0]   m_axi_awaddr;
  logic [NUM_PORTS*AW-1:0]   m_axi_araddr;
  logic [NUM_PORTS*3-1:0]    m_axi_awprot;
  logic [NUM_PORTS*3-1:0]    m_axi_arprot;
  logic [NUM_PORTS*32-1:0]   m_axi_wdata;
  logic [NUM_PORTS*4-1:0]    m_axi_wstrb;
  logic [NUM_PORTS-1:0]      m_axi_awvalid;
  logic [NUM_PORTS-1:0]      m_axi_wvalid;
  logic [NUM_PORTS-1:0]      m_axi_arvalid;
  logic [NUM_PORTS-1:0]      m_axi_bready;
  logic [NUM_PORTS-1:0]      m_axi_rready;
  logic [NUM_PORTS-1:0]      m_axi_awready;
  logic [NUM_PORTS-1:0]      m_axi_wready;
  logic [NUM_PORTS-1:0]      m_axi_arready;
  logic [NUM_PORTS-1:0]      m_axi_bvalid;
  logic [NUM_PORTS-1:0]      m_axi_rvalid;
  logic [NUM_PORTS*2-1:0]    m_axi_bresp;
  logic [NUM_PORTS*2-1:0]    m_axi_rresp;
  logic [NUM_PORTS*32-1:0]   m_axi_rdata;

  // Bridge view: Wishbone slave side, AXI-Lite master side
  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_ack_o, wb_err_o, wb_dat_o,
    output m_axi_awaddr, m_axi_araddr, m_axi_awprot, m_axi_arprot, m_axi_wdata, m_axi_wstrb,
    output m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
    input  m_axi_awready, m_axi_wready, m_axi_arready, m_axi_bvalid, m_axi_rvalid,
    input  m_axi_bresp, m_axi_rresp, m_axi_rdata
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_ack_o, wb_err_o, wb_dat_o,
    input  m_axi_awaddr, m_axi_araddr, m_axi_awprot, m_axi_arprot, m_axi_wdata, m_axi_wstrb,
    input  m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
    output m_axi_awready, m_axi_wready, m_axi_arready, m_axi_bvalid, m_axi_rvalid,
    output m_axi_bresp, m_axi_rresp, m_axi_rdata
  );
endinterface

// File: rtl/wb_axil_xbar_bridge.sv
// rtl/wb_axil_xbar_bridge.sv - Wishbone-classic slave to NUM_PORTS address-decoded AXI4-Lite masters, one outstanding
// transfer; optional hung-transfer watchdog enabled by WB_AXIL_TIMEOUT_EN
module wb_axil_xbar_bridge #(
  parameter int                      NUM_PORTS      = 4,
  parameter int                      AW             = 32,
  parameter logic [NUM_PORTS*AW-1:0] BASE_ADDR      = '0,
  parameter logic [NUM_PORTS*AW-1:0] ADDR_MASK      = '0,
  parameter int                      TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  wb_axil_xbar_bridge_if.slave  bus
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  port_q, port_d;
  logic [AW-1:0]  adr_q, adr_d;
  logic [31:0]    dat_q, dat_d;
  logic [3:0]     sel_q, sel_d;
  logic           aw_done_q, aw_done_d;
  logic           w_done_q, w_done_d;
  logic           err_q, err_d;
  logic [31:0]    rdata_q, rdata_d;

  logic           hit;
  logic [PW-1:0]  hit_idx;
  logic [NUM_PORTS-1:0] port_oh;
  int             p;

  // Descending scan so the lowest matching index is the one left standing
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if ((bus.wb_adr_i & ADDR_MASK[i*AW +: AW]) == BASE_ADDR[i*AW +: AW]) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  assign p       = int'(port_q);
  assign port_oh = NUM_PORTS'(1) << port_q;

`ifdef WB_AXIL_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.wb_cyc_i && bus.wb_stb_i) begin
          adr_d     = bus.wb_adr_i;
          dat_d     = bus.wb_dat_i;
          sel_d     = bus.wb_sel_i;
          port_d    = hit_idx;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          err_d     = !hit;
          if (!hit)              state_d = S_DONE;
          else if (bus.wb_we_i)  state_d = S_WR;
          else                   state_d = S_RD_ADDR;
        end
      end
      S_WR: begin
        if (bus.m_axi_awready[p]) aw_done_d = 1'b1;
        if (bus.m_axi_wready[p])  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (bus.m_axi_bvalid[p]) begin
          err_d   = bus.m_axi_bresp[2*p+1];
          state_d = S_DONE;
        end
      end
      S_RD_ADDR: begin
        if (bus.m_axi_arready[p]) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (bus.m_axi_rvalid[p]) begin
          err_d = bus.m_axi_rresp[2*p+1];
          if (!bus.m_axi_rresp[2*p+1]) rdata_d = bus.m_axi_rdata[p*32 +: 32];
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef WB_AXIL_TIMEOUT_EN
    cnt_d = '0;
    if (state_q != S_IDLE && state_q != S_DONE && state_d == state_q) begin
      if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
        state_d = S_DONE;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      port_q    <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef WB_AXIL_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT_CYCLES);
`endif

  logic unused_resp;
  assign unused_resp = ^{bus.m_axi_bresp, bus.m_axi_rresp};

  // Valids/readies derive from registered state only, so reset clears them at once
  assign bus.m_axi_awvalid = (state_q == S_WR && !aw_done_q) ? port_oh : '0;
  assign bus.m_axi_wvalid  = (state_q == S_WR && !w_done_q)  ? port_oh : '0;
  assign bus.m_axi_bready  = (state_q == S_WR_RESP)          ? port_oh : '0;
  assign bus.m_axi_arvalid = (state_q == S_RD_ADDR)          ? port_oh : '0;
  assign bus.m_axi_rready  = (state_q == S_RD_DATA)          ? port_oh : '0;

  assign bus.m_axi_awaddr = {NUM_PORTS{adr_q}};
  assign bus.m_axi_araddr = {NUM_PORTS{adr_q}};
  assign bus.m_axi_awprot = '0;
  assign bus.m_axi_arprot = '0;
  assign bus.m_axi_wdata  = {NUM_PORTS{dat_q}};
  assign bus.m_axi_wstrb  = {NUM_PORTS{sel_q}};

  assign bus.wb_ack_o = (state_q == S_DONE) && !err_q;
  assign bus.wb_err_o = (state_q == S_DONE) && err_q;
  assign bus.wb_dat_o = rdata_q;
endmodule

// File: tb/tb_wb_axil_xbar_bridge.sv
// tb/tb_wb_axil_xbar_bridge.sv - directed-vector bench for wb_axil_xbar_bridge
`timescale 1ns/1ps
module tb_wb_axil_xbar_bridge;
  localparam int NP = 4;
  localparam int AW = 32;
  // port0 0x1xxx_xxxx, port1 0x2xxx_xxxx, port2 0x9xxx_xxxx, port3 any bit31=0 (shadowed by 0/1)
  localparam logic [NP*AW-1:0] BASE = {32'h0000_0000, 32'h9000_0000, 32'h2000_0000, 32'h1000_0000};
  localparam logic [NP*AW-1:0] MASK = {32'h8000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_axil_xbar_bridge_if #(.NUM_PORTS(NP), .AW(AW)) bus();

  wb_axil_xbar_bridge #(
    .NUM_PORTS(NP), .AW(AW), .BASE_ADDR(BASE), .ADDR_MASK(MASK), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  int vectors = 0;
  int errors  = 0;

  int lat, n_ack, n_err, aw_hi, w_hi, ar_hi;
  logic [3:0] s_aw, s_w, s_ar, s_b, s_r, t_v, ws1;
  logic [31:0] wd1, aa1;

  task automatic clear_slave();
    bus.m_axi_awready = '0; bus.m_axi_wready = '0; bus.m_axi_arready = '0;
    bus.m_axi_bvalid  = '0; bus.m_axi_rvalid = '0;
    bus.m_axi_bresp   = '0; bus.m_axi_rresp  = '0; bus.m_axi_rdata = '0;
  endtask

  // One Wishbone transfer against a scripted slave on `port`; readies/valids rise at negedge index *_at.
  // A non-selected port continuously offers error responses that must be ignored.
  task automatic run_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat, input logic [3:0] sel,
                          input int port, input int ar_at, input int aw_at, input int w_at, input int b_at,
                          input int r_at, input logic [1:0] resp, input logic [31:0] rdat, input bit hold);
    int np;
    np = (port + 1) % NP;
    lat = 0; n_ack = 0; n_err = 0; aw_hi = 0; w_hi = 0; ar_hi = 0;
    s_aw = '0; s_w = '0; s_ar = '0; s_b = '0; s_r = '0; t_v = '0; ws1 = '0; wd1 = '0; aa1 = '0;
    bus.wb_adr_i = adr; bus.wb_we_i = we; bus.wb_dat_i = dat; bus.wb_sel_i = sel;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    clear_slave();
    bus.m_axi_bvalid[np] = 1'b1; bus.m_axi_rvalid[np] = 1'b1;
    bus.m_axi_bresp[np*2 +: 2] = 2'b10; bus.m_axi_rresp[np*2 +: 2] = 2'b10;
    bus.m_axi_rdata[np*32 +: 32] = 32'hBAD0_BAD0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      s_aw |= bus.m_axi_awvalid; s_w |= bus.m_axi_wvalid; s_ar |= bus.m_axi_arvalid;
      s_b  |= bus.m_axi_bready;  s_r |= bus.m_axi_rready;
      if (bus.m_axi_awvalid[port]) aw_hi++;
      if (bus.m_axi_wvalid[port])  w_hi++;
      if (bus.m_axi_arvalid[port]) ar_hi++;
      if (k == 1) begin
        wd1 = bus.m_axi_wdata[port*32 +: 32];
        ws1 = bus.m_axi_wstrb[port*4 +: 4];
        aa1 = we ? bus.m_axi_awaddr[port*AW +: AW] : bus.m_axi_araddr[port*AW +: AW];
      end
      if (bus.wb_ack_o || bus.wb_err_o) begin
        lat = k;
        n_ack += int'(bus.wb_ack_o);
        n_err += int'(bus.wb_err_o);
        t_v = bus.m_axi_awvalid | bus.m_axi_wvalid | bus.m_axi_arvalid | bus.m_axi_bready | bus.m_axi_rready;
        break;
      end
      bus.m_axi_awready[port] = (k >= aw_at);
      bus.m_axi_wready[port]  = (k >= w_at);
      bus.m_axi_arready[port] = (k >= ar_at);
      bus.m_axi_bvalid[port]  = (k >= b_at);
      bus.m_axi_rvalid[port]  = (k >= r_at);
      bus.m_axi_bresp[port*2 +: 2] = resp;
      bus.m_axi_rresp[port*2 +: 2] = resp;
      bus.m_axi_rdata[port*32 +: 32] = rdat;
    end
    clear_slave();
    if (!hold) begin
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
      @(negedge clk);
      n_ack += int'(bus.wb_ack_o);
      n_err += int'(bus.wb_err_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
    clear_slave();
    repeat (2) @(negedge clk);
    vectors++; if ((bus.m_axi_awvalid | bus.m_axi_wvalid) !== 4'b0) begin errors++; $display("FAIL reset_wvalids: got %b exp 0000", bus.m_axi_awvalid | bus.m_axi_wvalid); end
    vectors++; if ((bus.m_axi_arvalid | bus.m_axi_bready | bus.m_axi_rready) !== 4'b0) begin errors++; $display("FAIL reset_rvalids: got %b exp 0000", bus.m_axi_arvalid | bus.m_axi_bready | bus.m_axi_rready); end
    vectors++; if ({bus.wb_ack_o, bus.wb_err_o} !== 2'b00) begin errors++; $display("FAIL reset_term: got %b exp 00", {bus.wb_ack_o, bus.wb_err_o}); end
    vectors++; if (bus.wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h exp 00000000", bus.wb_dat_o); end
    vectors++; if ((bus.m_axi_awprot | bus.m_axi_arprot) !== 12'h0) begin errors++; $display("FAIL reset_prot: got %h exp 000", bus.m_axi_awprot | bus.m_axi_arprot); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_port2();
    run_xfer(32'h9000_0010, 1'b0, 32'h0, 4'hF, 2, 1, 99, 99, 99, 1, 2'b00, 32'hDEAD_BEEF, 1'b0);
    vectors++; if (lat !== 3) begin errors++; $display("FAIL rd2_latency: got %0d exp 3", lat); end
    vectors++; if (n_ack !== 1 || n_err !== 0) begin errors++; $display("FAIL rd2_term: got ack %0d err %0d exp 1/0", n_ack, n_err); end
    vectors++; if (s_ar !== 4'b0100 || s_r !== 4'b0100) begin errors++; $display("FAIL rd2_ports: got ar %b r %b exp 0100", s_ar, s_r); end
    vectors++; if ((s_aw | s_w | s_b) !== 4'b0) begin errors++; $display("FAIL rd2_no_write: got %b exp 0000", s_aw | s_w | s_b); end
    vectors++; if (aa1 !== 32'h9000_0010) begin errors++; $display("FAIL rd2_araddr: got %h exp 90000010", aa1); end
    vectors++; if (bus.wb_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd2_data: got %h exp deadbeef", bus.wb_dat_o); end
    vectors++; if (t_v !== 4'b0) begin errors++; $display("FAIL rd2_done_idle: got %b exp 0000", t_v); end
  endtask

  task automatic test_write_port0();
    run_xfer(32'h1000_0004, 1'b1, 32'h1234_5678, 4'b0110, 0, 99, 1, 3, 1, 99, 2'b00, 32'h0, 1'b0);
    vectors++; if (lat !== 5) begin errors++; $display("FAIL wr0_latency: got %0d exp 5", lat); end
    vectors++; if (n_ack !== 1 || n_err !== 0) begin errors++; $display("FAIL wr0_term: got ack %0d err %0d exp 1/0", n_ack, n_err); end
    vectors++; if (ws1 !== 4'b0110 || wd1 !== 32'h1234_5678) begin errors++; $display("FAIL wr0_wbus: got %b/%h exp 0110/12345678", ws1, wd1); end
    vectors++; if (aa1 !== 32'h1000_0004) begin errors++; $display("FAIL wr0_awaddr: got %h exp 10000004", aa1); end
    vectors++; if (aw_hi !== 1 || w_hi !== 3) begin errors++; $display("FAIL wr0_valid_cycles: got aw %0d w %0d exp 1/3", aw_hi, w_hi); end
    vectors++; if (s_aw !== 4'b0001 || s_b !== 4'b0001 || s_ar !== 4'b0) begin errors++; $display("FAIL wr0_ports: got aw %b b %b ar %b exp 0001/0001/0000", s_aw, s_b, s_ar); end
    vectors++; if (bus.wb_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr0_dat_hold: got %h exp deadbeef", bus.wb_dat_o); end
  endtask

  task automatic test_resp_codes();
    run_xfer(32'h2000_0008, 1'b0, 32'h0, 4'hF, 1, 1, 99, 99, 99, 1, 2'b10, 32'h1111_2222, 1'b0);
    vectors++; if (n_err !== 1 || n_ack !== 0 || lat !== 3) begin errors++; $display("FAIL rd_slverr: got err %0d ack %0d lat %0d exp 1/0/3", n_err, n_ack, lat); end
    vectors++; if (s_ar !== 4'b0010) begin errors++; $display("FAIL rd_slverr_port: got %b exp 0010", s_ar); end
    run_xfer(32'h4000_0100, 1'b1, 32'hCAFE_0001, 4'hF, 3, 99, 1, 1, 1, 99, 2'b01, 32'h0, 1'b0);
    vectors++; if (n_ack !== 1 || n_err !== 0 || lat !== 3) begin errors++; $display("FAIL wr_exokay: got ack %0d err %0d lat %0d exp 1/0/3", n_ack, n_err, lat); end
    vectors++; if (s_aw !== 4'b1000 || s_w !== 4'b1000) begin errors++; $display("FAIL wr_exokay_port: got %b/%b exp 1000", s_aw, s_w); end
    run_xfer(32'h2000_0000, 1'b1, 32'h0, 4'hF, 1, 99, 1, 1, 1, 99, 2'b11, 32'h0, 1'b0);
    vectors++; if (n_err !== 1 || n_ack !== 0) begin errors++; $display("FAIL wr_decerr: got err %0d ack %0d exp 1/0", n_err, n_ack); end
  endtask

  task automatic test_decode_miss();
    run_xfer(32'hF000_0000, 1'b0, 32'h0, 4'hF, 0, 1, 1, 1, 1, 1, 2'b00, 32'h5555_5555, 1'b0);
    vectors++; if (lat !== 1) begin errors++; $display("FAIL miss_latency: got %0d exp 1", lat); end
    vectors++; if (n_err !== 1 || n_ack !== 0) begin errors++; $display("FAIL miss_term: got err %0d ack %0d exp 1/0", n_err, n_ack); end
    vectors++; if ((s_aw | s_w | s_ar | s_b | s_r) !== 4'b0) begin errors++; $display("FAIL miss_no_axi: got %b exp 0000", s_aw | s_w | s_ar | s_b | s_r); end
    vectors++; if (bus.wb_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL miss_dat_hold: got %h exp deadbeef", bus.wb_dat_o); end
  endtask

  task automatic test_back_to_back();
    run_xfer(32'h9000_0020, 1'b0, 32'h0, 4'hF, 2, 1, 99, 99, 99, 1, 2'b00, 32'hA5A5_0001, 1'b1);
    vectors++; if (lat !== 3 || n_ack !== 1) begin errors++; $display("FAIL b2b_first: got lat %0d ack %0d exp 3/1", lat, n_ack); end
    run_xfer(32'h2000_0004, 1'b0, 32'h0, 4'hF, 1, 1, 99, 99, 99, 1, 2'b00, 32'h0000_00C3, 1'b0);
    vectors++; if (lat !== 4 || n_ack !== 1 || n_err !== 0) begin errors++; $display("FAIL b2b_second: got lat %0d ack %0d err %0d exp 4/1/0", lat, n_ack, n_err); end
    vectors++; if (bus.wb_dat_o !== 32'h0000_00C3) begin errors++; $display("FAIL b2b_data: got %h exp 000000c3", bus.wb_dat_o); end
  endtask

  task automatic test_reset_mid();
    bus.wb_adr_i = 32'h1000_0008; bus.wb_we_i = 1'b1; bus.wb_dat_i = 32'h0BAD_F00D; bus.wb_sel_i = 4'hF;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    clear_slave();
    bus.m_axi_awready[0] = 1'b1; bus.m_axi_wready[0] = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (bus.m_axi_bready !== 4'b0001) begin errors++; $display("FAIL rstmid_in_wr_resp: got %b exp 0001", bus.m_axi_bready); end
    rst = 1'b1;
    #1;
    vectors++; if ((bus.m_axi_awvalid | bus.m_axi_wvalid | bus.m_axi_arvalid | bus.m_axi_bready | bus.m_axi_rready) !== 4'b0) begin errors++; $display("FAIL rstmid_valids: got %b exp 0000", bus.m_axi_awvalid | bus.m_axi_wvalid | bus.m_axi_arvalid | bus.m_axi_bready | bus.m_axi_rready); end
    clear_slave();
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    @(negedge clk);
    vectors++; if ({bus.wb_ack_o, bus.wb_err_o} !== 2'b00) begin errors++; $display("FAIL rstmid_no_term: got %b exp 00", {bus.wb_ack_o, bus.wb_err_o}); end
    rst = 1'b0;
    @(negedge clk);
    run_xfer(32'h4000_0040, 1'b0, 32'h0, 4'hF, 3, 1, 99, 99, 99, 1, 2'b00, 32'h0F0F_0F0F, 1'b0);
    vectors++; if (lat !== 3 || n_ack !== 1 || n_err !== 0) begin errors++; $display("FAIL rstmid_after: got lat %0d ack %0d err %0d exp 3/1/0", lat, n_ack, n_err); end
    vectors++; if (bus.wb_dat_o !== 32'h0F0F_0F0F || s_ar !== 4'b1000) begin errors++; $display("FAIL rstmid_after_data: got %h/%b exp 0f0f0f0f/1000", bus.wb_dat_o, s_ar); end
  endtask

`ifdef WB_AXIL_TIMEOUT_EN
  task automatic test_timeout();
    run_xfer(32'h9000_0030, 1'b0, 32'h0, 4'hF, 2, 999, 99, 99, 99, 1, 2'b00, 32'h0, 1'b0);
    vectors++; if (lat !== 17 || n_err !== 1 || n_ack !== 0) begin errors++; $display("FAIL tmo_term: got lat %0d err %0d ack %0d exp 17/1/0", lat, n_err, n_ack); end
    vectors++; if (ar_hi !== 16 || t_v !== 4'b0) begin errors++; $display("FAIL tmo_arvalid: got %0d cycles, %b at err exp 16/0000", ar_hi, t_v); end
    run_xfer(32'h2000_0010, 1'b0, 32'h0, 4'hF, 1, 1, 99, 99, 99, 1, 2'b00, 32'h0000_7777, 1'b0);
    vectors++; if (lat !== 3 || n_ack !== 1 || bus.wb_dat_o !== 32'h0000_7777) begin errors++; $display("FAIL tmo_recover: got lat %0d ack %0d dat %h exp 3/1/00007777", lat, n_ack, bus.wb_dat_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_port2();
    test_write_port0();
    test_resp_codes();
    test_decode_miss();
    test_back_to_back();
    test_reset_mid();
`ifdef WB_AXIL_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, %0d vectors applied", vectors);
    $fatal(1);
  end
endmodule

// File: doc/wb_axil_xbar_bridge.md
# wb_axil_xbar_bridge

Wishbone-classic slave to multi-port AXI4-Lite master bridge sitting between the NEORV32 external bus and the on-board register blocks. Generalises the single-port Wishbone/AXI-Lite bridge: NUM_PORTS address-decoded AXI-Lite master ports, one outstanding transaction, AXI response codes mapped to wb_ack_o/wb_err_o, and an optional watchdog that terminates hung transfers.

## Interface
- NUM_PORTS, 4: number of AXI-Lite master ports (1..16).
- AW, 32: address width on both buses; data width is fixed at 32.
- BASE_ADDR, {NUM_PORTS{32'h0}}: flattened NUM_PORTS*AW vector; port i base at [i*AW +: AW].
- ADDR_MASK, {NUM_PORTS{32'h0}}: flattened NUM_PORTS*AW vector; port i matches when (wb_adr_i & mask_i) == base_i.
- TIMEOUT_CYCLES, 1024: watchdog limit in clk_i cycles (16-bit counter; legal 2..65535).

Ports:
- clk_i  in  1  single clock for both buses.
- rst_i  in  1  asynchronous, active-high reset.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone-classic request.
- wb_adr_i  in  AW  byte address.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte enables.
- wb_ack_o, wb_err_o  out  1 each  single-cycle termination pulses.
- wb_dat_o  out  32  read data.
- m_axi_awaddr, m_axi_araddr  out  NUM_PORTS*AW  per-port address.
- m_axi_awprot, m_axi_arprot  out  NUM_PORTS*3  constant 3'b000.
- m_axi_wdata  out  NUM_PORTS*32; m_axi_wstrb  out  NUM_PORTS*4.
- m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready  out  NUM_PORTS  per-port handshake.
- m_axi_awready, m_axi_wready, m_axi_arready, m_axi_bvalid, m_axi_rvalid  in  NUM_PORTS.
- m_axi_bresp, m_axi_rresp  in  NUM_PORTS*2; m_axi_rdata  in  NUM_PORTS*32.

## Operation
- States: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: on wb_cyc_i & wb_stb_i, decode address; lowest-index matching port wins; register port index, address, data, sel, we.
- No match: no AXI activity; wb_err_o pulses next cycle; stay IDLE.
- Write: WR asserts awvalid and wvalid of selected port; each dropped independently on its ready; both accepted -> WR_RESP with bready high; bvalid -> DONE.
- Read: RD_ADDR asserts arvalid until arready -> RD_DATA with rready high; rvalid -> latch rdata into wb_dat_o -> DONE.
- DONE: one-cycle pulse of wb_ack_o (resp 00/01) or wb_err_o (resp 10/11); return IDLE.
- Address/data/strobe buses broadcast to all ports; only the selected port's valid/ready is ever high (one-hot or zero).
- Responses (bvalid/rvalid) arriving outside the expected state or from a non-selected port are ignored.
- wb_dat_o holds its last read value; writes and errors do not change it.

## Timing
- Reset values: all valid/ready outputs 0, wb_ack_o 0, wb_err_o 0, wb_dat_o 0, state IDLE.
- Reset asserted mid-transaction: outputs to reset values immediately, transaction abandoned, no termination pulse.
- Minimum latency stb-sampled to ack: 3 cycles for read and write (ready/valid returned in the same cycle they are first seen).
- Decode miss: err 1 cycle after stb sampled.
- Next request accepted in the cycle after the ack/err pulse; back-to-back stb without deassertion is legal.
- wb_cyc_i dropped mid-transaction: AXI transfer still completes; termination pulse still issued.

## Configuration
- WB_AXIL_TIMEOUT_EN defined: counter starts on leaving IDLE, resets on each state change; reaching TIMEOUT_CYCLES in any non-IDLE state drops all valids/readies, pulses wb_err_o next cycle, returns IDLE.
- Not defined: no counter; a missing ready/valid stalls the bridge indefinitely.

## Test plan
- Read port 2 (base 0x9000_0000, mask 0xF000_0000) at 0x9000_0010, slave returns 0xDEADBEEF/OKAY with zero wait -> arvalid only on port 2, wb_ack_o 3 cycles after stb, wb_dat_o=0xDEADBEEF.
- Write 0x1234_5678 sel 4'b0110 to port 0, awready 2 cycles before wready -> wstrb 4'b0110, awvalid drops first, single wb_ack_o after bvalid.
- Read returning rresp=2'b10 -> wb_err_o one pulse, wb_ack_o stays 0.
- Address 0xF000_0000 matching no port -> wb_err_o 1 cycle after stb, no AXI valid on any port.
- With WB_AXIL_TIMEOUT_EN, TIMEOUT_CYCLES=16, arready held 0 -> arvalid drops and wb_err_o pulses after 16 cycles; following read to another port completes normally.
- rst_i asserted while in WR_RESP -> all valids/readies 0 same cycle, no ack/err, next request after release behaves normally.
